// File: rtl/esync_array.sv
// rtl/esync_array.sv - multi-channel input synchroniser, debouncer and edge-event latch
//
// Purpose: each of CH asynchronous level inputs is synchronised through a LEN-stage
// flop chain, debounced over FLT cycles, and its qualifying edges are reported as a
// one-cycle pulse plus sticky pending/overrun flags.
//
// Ports:
//   clk   - single clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   in    - [CH]   asynchronous level inputs
//   mode  - [2*CH] per-channel edge select at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr   - [CH]   per-channel sticky flag clear
//   lvl   - [CH]   synchronised, debounced level
//   evt   - [CH]   one-cycle pulse per qualifying edge
//   pend  - [CH]   sticky event-pending flag
//   ovf   - [CH]   sticky overrun flag (event while pend already set)
module esync_array #(
  parameter int CH  = 4,
  parameter int LEN = 3,
  parameter int FLT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   lvl,
  output logic [CH-1:0]   evt,
  output logic [CH-1:0]   pend,
  output logic [CH-1:0]   ovf
);

  localparam int CW = $clog2(FLT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLT - 1);

  if (LEN < 2) begin : g_len_chk
    $error("esync_array: LEN must be >= 2");
  end
  if (FLT < 1) begin : g_flt_chk
    $error("esync_array: FLT must be >= 1");
  end
  if (CH < 1 || CH > 32) begin : g_ch_chk
    $error("esync_array: CH must be in 1..32");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [LEN-1:0] sync_q;
    logic [CW-1:0]  cnt_q;
    logic           lvl_q;
    logic           evt_q;
    logic           pend_q;
    logic           ovf_q;
    logic           s;
    logic           flip;
    logic           hit;

    assign s = sync_q[LEN-1];

    // The level flips once the mismatch has persisted for FLT consecutive cycles;
    // the counter only reaches FLT-1 after FLT-1 mismatching cycles.
    assign flip = (s != lvl_q) && (cnt_q == CNT_LAST);

    // After a flip the new level equals s, so s selects which mode bit applies.
    assign hit = flip && (s ? mode[2*i] : mode[2*i+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        evt_q  <= 1'b0;
        pend_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[LEN-2:0], in[i]};

        if (s == lvl_q || flip) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end

        if (flip) begin
          lvl_q <= s;
        end

        evt_q <= hit;

        // A new event beats a simultaneous clear: pend stays set, overrun is dropped.
        if (hit) begin
          pend_q <= 1'b1;
        end else if (clr[i]) begin
          pend_q <= 1'b0;
        end

        if (clr[i]) begin
          ovf_q <= 1'b0;
        end else if (hit && pend_q) begin
          ovf_q <= 1'b1;
        end
      end
    end

    assign lvl[i]  = lvl_q;
    assign evt[i]  = evt_q;
    assign pend[i] = pend_q;
    assign ovf[i]  = ovf_q;
  end

endmodule

// File: tb/tb_esync_array.sv
// tb/tb_esync_array.sv - scoreboard testbench for esync_array
module tb_esync_array;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  v;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_a;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] lvl, evt, pend, ovf;

  logic [3:0] in_b;
  logic [7:0] mode_b;
  logic [3:0] clr_b;
  logic [3:0] lvl_b, evt_b, pend_b, ovf_b;

  int unsigned cyc;
  int          pass_cnt;
  int          total_cnt;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t exp_b[$];
  ev_t obs_b[$];

  esync_array #(.CH(4), .LEN(3), .FLT(4)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_a),
    .mode (mode),
    .clr  (clr),
    .lvl  (lvl),
    .evt  (evt),
    .pend (pend),
    .ovf  (ovf)
  );

  esync_array #(.CH(4), .LEN(2), .FLT(1)) u_fast (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_b),
    .mode (mode_b),
    .clr  (clr_b),
    .lvl  (lvl_b),
    .evt  (evt_b),
    .pend (pend_b),
    .ovf  (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every observed event pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (evt != 4'b0) begin
      ev_t r;
      r.cyc = cyc;
      r.v   = evt;
      obs_q.push_back(r);
    end
    if (evt_b != 4'b0) begin
      ev_t r;
      r.cyc = cyc;
      r.v   = evt_b;
      obs_b.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(int unsigned c, logic [3:0] v);
    ev_t r;
    r.cyc = c;
    r.v   = v;
    return r;
  endfunction

  task automatic clear_flags();
    clr = 4'hF;
    @(negedge clk);
    clr = 4'h0;
  endtask

  task automatic test_reset();
    ev_t e, o;
    rst_n = 1'b0; in_a = 4'b0001; mode = 8'h55; clr = 4'h0;
    in_b = 4'h0; mode_b = 8'h00; clr_b = 4'h0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({lvl, evt, pend, ovf} !== 16'h0) $display("FAIL reset_outputs: got %h required 0000", {lvl, evt, pend, ovf});
    else pass_cnt++;
    total_cnt++;
    if ({lvl_b, evt_b, pend_b, ovf_b} !== 16'h0) $display("FAIL reset_outputs_fast: got %h required 0000", {lvl_b, evt_b, pend_b, ovf_b});
    else pass_cnt++;
    // Input already high at release counts as a rising edge.
    rst_n = 1'b1;
    exp_q.push_back(mk(cyc + 7, 4'b0001));
    repeat (10) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL reset_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL reset_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (pend !== 4'b0001) $display("FAIL reset_pend: got %b required 0001", pend);
    else pass_cnt++;
    clear_flags();
    total_cnt++;
    if ({pend, ovf} !== 8'h0) $display("FAIL reset_clr: got pend/ovf %b required 00000000", {pend, ovf});
    else pass_cnt++;
    in_a = 4'b0000;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (lvl !== 4'b0000) $display("FAIL reset_fall_lvl: got %b required 0000", lvl);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 0) begin
      $display("FAIL reset_extra: got %0d unexpected evt pulses required 0", obs_q.size());
      obs_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    ev_t e, o;
    mode = 8'h55;
    in_a[0] = 1'b1;
    exp_q.push_back(mk(cyc + 7, 4'b0001));
    repeat (6) @(negedge clk);
    total_cnt++;
    if (lvl !== 4'b0000) $display("FAIL basic_early_lvl: got %b required 0000", lvl);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (lvl !== 4'b0001 || evt !== 4'b0001) $display("FAIL basic_edge: got lvl=%b evt=%b required 0001/0001", lvl, evt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (evt !== 4'b0000) $display("FAIL basic_pulse_width: got evt=%b required 0000", evt);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL basic_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (pend !== 4'b0001 || ovf !== 4'b0000) $display("FAIL basic_flags: got pend=%b ovf=%b required 0001/0000", pend, ovf);
    else pass_cnt++;
    clear_flags();
    in_a[0] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_debounce();
    ev_t e, o;
    mode = 8'h55;
    in_a[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_a[1] = 1'b0;
    repeat (12) @(negedge clk);
    total_cnt++;
    if (lvl[1] !== 1'b0 || pend[1] !== 1'b0 || obs_q.size() != 0)
      $display("FAIL debounce_short: got lvl1=%b pend1=%b evts=%0d required 0/0/0", lvl[1], pend[1], obs_q.size());
    else pass_cnt++;
    obs_q.delete();
    in_a[1] = 1'b1;
    exp_q.push_back(mk(cyc + 7, 4'b0010));
    repeat (5) @(negedge clk);
    in_a[1] = 1'b0;
    repeat (15) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL debounce_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL debounce_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_q.size() != 0 || pend !== 4'b0010) begin
      $display("FAIL debounce_after: got extra=%0d pend=%b required 0/0010", obs_q.size(), pend);
      obs_q.delete();
    end else pass_cnt++;
    clear_flags();
  endtask

  task automatic test_both_edges();
    ev_t e, o;
    mode = 8'b01_11_01_01;
    in_a[2] = 1'b1;
    exp_q.push_back(mk(cyc + 7, 4'b0100));
    repeat (20) @(negedge clk);
    in_a[2] = 1'b0;
    exp_q.push_back(mk(cyc + 7, 4'b0100));
    repeat (12) @(negedge clk);
    total_cnt++;
    if (pend !== 4'b0100 || ovf !== 4'b0100) $display("FAIL both_flags: got pend=%b ovf=%b required 0100/0100", pend, ovf);
    else pass_cnt++;
    clear_flags();
    mode = 8'b01_10_01_01;
    in_a[2] = 1'b1;
    repeat (20) @(negedge clk);
    in_a[2] = 1'b0;
    exp_q.push_back(mk(cyc + 7, 4'b0100));
    repeat (12) @(negedge clk);
    total_cnt++;
    if (pend !== 4'b0100 || ovf !== 4'b0000) $display("FAIL fall_flags: got pend=%b ovf=%b required 0100/0000", pend, ovf);
    else pass_cnt++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL both_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL both_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      $display("FAIL both_extra: got %0d unexpected evt pulses required 0", obs_q.size());
      obs_q.delete();
    end else pass_cnt++;
    clear_flags();
  endtask

  task automatic test_clr_collision();
    ev_t e, o;
    mode = 8'b11_01_01_01;
    in_a[3] = 1'b1;
    exp_q.push_back(mk(cyc + 7, 4'b1000));
    repeat (20) @(negedge clk);
    in_a[3] = 1'b0;
    exp_q.push_back(mk(cyc + 7, 4'b1000));
    repeat (6) @(negedge clk);
    clr = 4'b1000;
    @(negedge clk);
    total_cnt++;
    if (evt !== 4'b1000 || pend !== 4'b1000 || ovf !== 4'b0000)
      $display("FAIL clr_collision: got evt=%b pend=%b ovf=%b required 1000/1000/0000", evt, pend, ovf);
    else pass_cnt++;
    @(negedge clk);
    clr = 4'b0000;
    total_cnt++;
    if (pend !== 4'b0000 || ovf !== 4'b0000) $display("FAIL clr_alone: got pend=%b ovf=%b required 0000/0000", pend, ovf);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL clr_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL clr_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      $display("FAIL clr_extra: got %0d unexpected evt pulses required 0", obs_q.size());
      obs_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mode = 8'h55;
    in_a = 4'b0001;
    repeat (4) @(negedge clk);
    in_a = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({lvl, evt, pend, ovf} !== 16'h0) $display("FAIL midreset_outputs: got %h required 0000", {lvl, evt, pend, ovf});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    total_cnt++;
    if ({lvl, evt, pend, ovf} !== 16'h0 || obs_q.size() != 0) begin
      $display("FAIL midreset_after: got outputs=%h evts=%0d required 0000/0", {lvl, evt, pend, ovf}, obs_q.size());
      obs_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_random();
    ev_t e, o;
    logic [3:0] nv, q;
    int exp_cnt[4];
    int got_cnt[4];
    for (int j = 0; j < 4; j++) begin
      exp_cnt[j] = 0;
      got_cnt[j] = 0;
    end
    obs_b.delete();
    mode_b = 8'b11_10_01_00;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      nv = in_b ^ 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) begin
        q[j] = (nv[j] != in_b[j]) && (nv[j] ? mode_b[2*j] : mode_b[2*j+1]);
        if (q[j]) exp_cnt[j]++;
      end
      if (q != 4'b0) exp_b.push_back(mk(cyc + 3, q));
      in_b = nv;
    end
    repeat (6) @(negedge clk);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      total_cnt++;
      if (obs_b.size() == 0) $display("FAIL random_evt: missing evt=%b due cycle %0d", e.v, e.cyc);
      else begin
        o = obs_b.pop_front();
        for (int j = 0; j < 4; j++) if (o.v[j]) got_cnt[j]++;
        if (o !== e) $display("FAIL random_evt: got evt=%b at cycle %0d required evt=%b at cycle %0d", o.v, o.cyc, e.v, e.cyc);
        else pass_cnt++;
      end
    end
    while (obs_b.size() != 0) begin
      o = obs_b.pop_front();
      for (int j = 0; j < 4; j++) if (o.v[j]) got_cnt[j]++;
    end
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if (got_cnt[j] != exp_cnt[j]) $display("FAIL random_count ch%0d: got %0d required %0d", j, got_cnt[j], exp_cnt[j]);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_debounce();
    test_both_edges();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
